fdiv_iter: RTL

Parametrised, multi-cycle IEEE-754 floating-point divider for single (N=32) or double (N=64) precision. It uses radix-2 restoring mantissa division, round-to-nearest-even and IEEE special-case handling. Operands and results pass through valid/ready handshakes, so the block sits as a pipeline stage in the FPU datapath and replaces the single-cycle divider where timing closure matters.

---
 rtl/fdiv_iter_if.sv | 27 ++
 rtl/fdiv_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative floating-point divider.
// The master side supplies operands and accepts results; the divider is the slave.
interface fdiv_iter_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         flag_dz;
    logic         flag_inv;
    logic         flag_ovf;
    logic         flag_unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, flag_dz, flag_inv, flag_ovf, flag_unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, flag_dz, flag_inv, flag_ovf, flag_unf
    );
endinterface

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 divider (N=32 or 64): radix-2 restoring mantissa division, RNE rounding,
// flush-to-zero on subnormal inputs and results. States: IDLE wait | CHECK classify | DIVIDE 1 bit/cycle | ROUND normalise+round | DONE hold result
module fdiv_iter #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_iter_if.slave  bus
);
    localparam int EXP_LEN = (N == 64) ? 11 : 8;
    localparam int MAN_LEN = (N == 64) ? 52 : 23;
    localparam int Q       = MAN_LEN + 3;
    localparam int CW      = $clog2(Q);
    localparam int EW      = EXP_LEN + 2;
    localparam int RW      = MAN_LEN + 2;
    localparam int BIAS_I  = (1 << (EXP_LEN - 1)) - 1;

    localparam logic [EW-1:0] BIAS     = EW'(BIAS_I);
    localparam logic [EW-2:0] EMAX     = {1'b0, {EXP_LEN{1'b1}}};
    localparam logic [CW-1:0] CNT_INIT = CW'(Q - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  out_q, out_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [Q-1:0]  quo_q, quo_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic          inv_q, inv_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [EXP_LEN-1:0] ea, eb;
    logic [MAN_LEN-1:0] fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan;
    logic               res_sign;
    logic [N-1:0]       inf_val, zero_val, qnan_val;

    assign ea       = a_q[N-2:MAN_LEN];
    assign eb       = b_q[N-2:MAN_LEN];
    assign fa       = a_q[MAN_LEN-1:0];
    assign fb       = b_q[MAN_LEN-1:0];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (&ea) && (fa == '0);
    assign b_inf    = (&eb) && (fb == '0);
    assign a_nan    = (&ea) && (fa != '0);
    assign b_nan    = (&eb) && (fb != '0);
    assign is_nan   = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign res_sign = a_q[N-1] ^ b_q[N-1];
    assign inf_val  = {res_sign, {EXP_LEN{1'b1}}, {MAN_LEN{1'b0}}};
    assign zero_val = {res_sign, {(N-1){1'b0}}};
    assign qnan_val = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MAN_LEN-1){1'b0}}};

    // One restoring step: the remainder never reaches 2*mb, so the shift loses nothing.
    logic [RW-1:0] mb_ext, rem_sub;
    logic          rem_ge;

    assign mb_ext  = {1'b0, 1'b1, fb};
    assign rem_ge  = (rem_q >= mb_ext);
    assign rem_sub = rem_ge ? (rem_q - mb_ext) : rem_q;

    logic               q_msb, guard, sticky, round_up, frac_carry;
    logic [MAN_LEN-1:0] frac_raw, frac_rnd;
    logic [EW-1:0]      e_norm, e_rnd;
    logic               ovf_c, unf_c;

    assign q_msb    = quo_q[Q-1];
    assign frac_raw = q_msb ? quo_q[Q-2:2] : quo_q[Q-3:1];
    assign guard    = q_msb ? quo_q[1] : quo_q[0];
    assign sticky   = (q_msb && quo_q[0]) || (rem_q != '0);
    assign round_up = guard && (sticky || frac_raw[0]);
    // The hidden bit is always 1 here, so a carry out of the fraction is a carry out of the significand.
    assign {frac_carry, frac_rnd} = {1'b0, frac_raw} + {{MAN_LEN{1'b0}}, round_up};
    assign e_norm   = exp_q - {{(EW-1){1'b0}}, ~q_msb};
    assign e_rnd    = e_norm + {{(EW-1){1'b0}}, frac_carry};
    assign ovf_c    = !e_rnd[EW-1] && (e_rnd[EW-2:0] >= EMAX);
    assign unf_c    = e_rnd[EW-1] || (e_rnd == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (is_nan) begin
                    out_d = qnan_val;
                    inv_d = 1'b1;
                end else if (a_inf) begin
                    out_d = inf_val;
                end else if (b_inf) begin
                    out_d = zero_val;
                end else if (b_zero) begin
                    out_d = inf_val;
                    dz_d  = 1'b1;
                end else if (a_zero) begin
                    out_d = zero_val;
                end else begin
                    rem_d   = {1'b0, 1'b1, fa};
                    quo_d   = '0;
                    exp_d   = {2'b00, ea} - {2'b00, eb} + BIAS;
                    cnt_d   = CNT_INIT;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[Q-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ROUND: begin
                state_d = DONE;
                ovf_d   = ovf_c;
                unf_d   = !ovf_c && unf_c;
                if (ovf_c) begin
                    out_d = inf_val;
                end else if (unf_c) begin
                    out_d = zero_val;
                end else begin
                    out_d = {res_sign, e_rnd[EXP_LEN-1:0], frac_rnd};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dz_d    = 1'b0;
                    inv_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.flag_dz   = dz_q;
    assign bus.flag_inv  = inv_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_unf  = unf_q;
endmodule
